quantum_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer and dispatch controller between the instruction memory and the two execution resources: the classical MIPS core and the quantum coprocessor (COP2). It owns the program counter and fetches one word at a time. It resolves J instructions itself and issues every other word through a valid/ready handshake to the classical or quantum side. For quantum gates it holds fetch until the coprocessor reports completion, which serialises gate execution.

---
 rtl/qpu_pkg.sv | 33 +++
 rtl/q_decode.sv | 34 +++
 rtl/quantum_fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_quantum_fetch_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_pkg.sv
// Shared definitions for the quantum fetch/dispatch path: opcodes, gate functs,
// sequencer states and the quantum gate payload.
package qpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPW   = 6;
    localparam int unsigned QIDXW = 5;
    localparam int unsigned RETW  = 16;

    localparam logic [OPW-1:0] OP_J    = 6'b000010;
    localparam logic [OPW-1:0] OP_COP2 = 6'b010010;
    localparam logic [OPW-1:0] QF_H    = 6'h01;
    localparam logic [OPW-1:0] QF_CNOT = 6'h04;

    localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam int unsigned     NUM_QUBITS_DEF = 2;
    localparam int unsigned     Q_TIMEOUT_DEF  = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_C_ISSUE = 3'd2,
        ST_Q_ISSUE = 3'd3,
        ST_Q_WAIT  = 3'd4
    } state_t;

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [QIDXW-1:0] ctrl;
        logic [QIDXW-1:0] tgt;
    } q_gate_t;

endpackage

// File: rtl/q_decode.sv
// Combinational COP2 field extraction and gate legality check; shared with the
// coprocessor-side checker.
module q_decode
    import qpu_pkg::*;
#(
    parameter int unsigned NUM_QUBITS = NUM_QUBITS_DEF
) (
    input  logic [XLEN-1:0] instr,
    output q_gate_t         gate_c,
    output logic            legal_c
);

    localparam logic [QIDXW-1:0] NQ = QIDXW'(NUM_QUBITS);

    logic tgt_ok;
    logic ctrl_ok;
    logic unused_bits;

    // Opcode is decoded by the caller; the middle field carries no gate info.
    assign unused_bits = ^{instr[31:26], instr[15:6]};

    always_comb begin
        gate_c  = '{op: instr[5:0], ctrl: instr[25:21], tgt: instr[20:16]};
        tgt_ok  = (gate_c.tgt != '0) && (gate_c.tgt <= NQ);
        ctrl_ok = (gate_c.ctrl != '0) && (gate_c.ctrl <= NQ) && (gate_c.ctrl != gate_c.tgt);
        legal_c = 1'b0;
        case (gate_c.op)
            QF_H:    legal_c = tgt_ok;
            QF_CNOT: legal_c = tgt_ok && ctrl_ok;
            default: legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/quantum_fetch_ctrl.sv
// Fetch sequencer: owns the PC, resolves J locally and dispatches other words
// to the classical core or the quantum coprocessor, serialising gates.
module quantum_fetch_ctrl
    import qpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int unsigned     NUM_QUBITS = NUM_QUBITS_DEF,
    parameter int unsigned     Q_TIMEOUT  = Q_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  instr,
    output logic             c_valid,
    output logic [XLEN-1:0]  c_instr,
    input  logic             c_ready,
    output logic             q_valid,
    output logic [OPW-1:0]   q_op,
    output logic [QIDXW-1:0] q_ctrl,
    output logic [QIDXW-1:0] q_tgt,
    input  logic             q_ready,
    input  logic             q_done,
    output logic             busy,
    output logic             err,
    output logic [RETW-1:0]  retired
);

    localparam int unsigned      TMO_W    = (Q_TIMEOUT > 2) ? $clog2(Q_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(Q_TIMEOUT - 1);

    state_t            state_q,   state_d;
    logic [XLEN-1:0]   pc_q,      pc_d;
    logic [XLEN-1:0]   c_instr_q, c_instr_d;
    q_gate_t           gate_q,    gate_d;
    logic              c_valid_q, c_valid_d;
    logic              q_valid_q, q_valid_d;
    logic              busy_q,    busy_d;
    logic              err_q,     err_d;
    logic [RETW-1:0]   retired_q, retired_d;
    logic [TMO_W-1:0]  tmo_q,     tmo_d;

    q_gate_t dec_gate;
    logic    dec_legal;

    q_decode #(.NUM_QUBITS(NUM_QUBITS)) u_q_decode (
        .instr   (instr),
        .gate_c  (dec_gate),
        .legal_c (dec_legal)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        c_instr_d = c_instr_q;
        gate_d    = gate_q;
        err_d     = err_q;
        retired_d = retired_q;
        tmo_d     = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (run && !err_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // run is honoured only here, so an issued instruction always finishes.
                if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    case (instr[31:26])
                        OP_J: begin
                            pc_d      = {pc_q[31:28], instr[25:0], 2'b00};
                            retired_d = retired_q + RETW'(1);
                        end
                        OP_COP2: begin
                            if (dec_legal) begin
                                gate_d  = dec_gate;
                                state_d = ST_Q_ISSUE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                        default: begin
                            c_instr_d = instr;
                            state_d   = ST_C_ISSUE;
                        end
                    endcase
                end
            end
            ST_C_ISSUE: begin
                if (c_ready) begin
                    pc_d      = pc_q + XLEN'(4);
                    retired_d = retired_q + RETW'(1);
                    state_d   = ST_FETCH;
                end
            end
            ST_Q_ISSUE: begin
                if (q_ready) begin
                    tmo_d   = '0;
                    state_d = ST_Q_WAIT;
                end
            end
            ST_Q_WAIT: begin
                // Completion takes priority over a timeout in the same cycle.
                if (q_done) begin
                    pc_d      = pc_q + XLEN'(4);
                    retired_d = retired_q + RETW'(1);
                    state_d   = ST_FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        c_valid_d = (state_d == ST_C_ISSUE);
        q_valid_d = (state_d == ST_Q_ISSUE);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            c_instr_q <= '0;
            gate_q    <= '0;
            c_valid_q <= 1'b0;
            q_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            c_instr_q <= c_instr_d;
            gate_q    <= gate_d;
            c_valid_q <= c_valid_d;
            q_valid_q <= q_valid_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
        end
    end

    assign pc      = pc_q;
    assign c_valid = c_valid_q;
    assign c_instr = c_instr_q;
    assign q_valid = q_valid_q;
    assign q_op    = gate_q.op;
    assign q_ctrl  = gate_q.ctrl;
    assign q_tgt   = gate_q.tgt;
    assign busy    = busy_q;
    assign err     = err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_quantum_fetch_ctrl.sv
// Self-checking bench for quantum_fetch_ctrl: instruction-level reference model
// driven by directed programs and randomized programs/handshake delays.
module tb_quantum_fetch_ctrl;

    localparam int unsigned QT = 255;
    localparam int unsigned NQ = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        c_ready = 1'b0;
    logic        q_ready = 1'b0;
    logic        q_done = 1'b0;
    logic [31:0] pc, instr, c_instr;
    logic        c_valid, q_valid, busy, err;
    logic [5:0]  q_op;
    logic [4:0]  q_ctrl, q_tgt;
    logic [15:0] retired;

    logic [31:0] rom [64];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;
    logic [15:0] exp_ret;
    bit          halted;

    assign instr = rom[pc[7:2]];

    always #5 clk = ~clk;

    quantum_fetch_ctrl #(.RESET_PC(32'h0), .NUM_QUBITS(NQ), .Q_TIMEOUT(QT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .pc(pc), .instr(instr),
        .c_valid(c_valid), .c_instr(c_instr), .c_ready(c_ready),
        .q_valid(q_valid), .q_op(q_op), .q_ctrl(q_ctrl), .q_tgt(q_tgt),
        .q_ready(q_ready), .q_done(q_done), .busy(busy), .err(err), .retired(retired)
    );

    // Gate legality straight from the instruction-set rules.
    function automatic bit gate_ok(input logic [31:0] w);
        int f, c, t;
        f = int'(w[5:0]);
        c = int'(w[25:21]);
        t = int'(w[20:16]);
        if (f != 1 && f != 4) return 1'b0;
        if (t < 1 || t > int'(NQ)) return 1'b0;
        if (f == 4 && (c < 1 || c > int'(NQ) || c == t)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0000;
    endtask

    task automatic load_demo();
        fill_nop();
        rom[0] = 32'h2008_0005;
        rom[1] = 32'h4802_0001;
        rom[2] = 32'h4822_0004;
        rom[3] = 32'h0800_0001;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; c_ready = 1'b0; q_ready = 1'b0; q_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 32'h0; exp_ret = 16'h0; halted = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        n_vec++;
        if ({busy, pc} !== {1'b1, exp_pc}) begin
            n_err++;
            $display("FAIL start: busy=%b pc=%h, want busy=1 pc=%h", busy, pc, exp_pc);
        end
    endtask

    // Execute the instruction at exp_pc with the given handshake shaping.
    task automatic exec_one(input int c_hold, input int q_hold, input int d_dly,
                            input bit early_done, input bit drop_run);
        logic [31:0] w;
        w = rom[exp_pc[7:2]];
        if (w[31:26] == 6'b000010) begin
            tick();
            exp_pc  = {exp_pc[31:28], w[25:0], 2'b00};
            exp_ret = exp_ret + 16'd1;
        end else if (w[31:26] == 6'b010010 && !gate_ok(w)) begin
            tick();
            n_vec++;
            if ({busy, err, q_valid, c_valid, pc, retired} !== {4'b0100, exp_pc, exp_ret}) begin
                n_err++;
                $display("FAIL illegal_op w=%h: busy,err,qv,cv=%b%b%b%b pc=%h ret=%0d, want 0100 pc=%h ret=%0d",
                         w, busy, err, q_valid, c_valid, pc, retired, exp_pc, exp_ret);
            end
            halted = 1'b1;
            return;
        end else if (w[31:26] == 6'b010010) begin
            tick();
            n_vec++;
            if ({q_valid, c_valid, q_op, q_ctrl, q_tgt} !== {2'b10, w[5:0], w[25:21], w[20:16]}) begin
                n_err++;
                $display("FAIL q_offer: qv=%b cv=%b op=%h ctrl=%0d tgt=%0d, want 1 0 op=%h ctrl=%0d tgt=%0d",
                         q_valid, c_valid, q_op, q_ctrl, q_tgt, w[5:0], w[25:21], w[20:16]);
            end
            for (int i = 0; i < q_hold; i++) begin
                tick();
                n_vec++;
                if ({q_valid, q_op, q_ctrl, q_tgt, pc} !== {1'b1, w[5:0], w[25:21], w[20:16], exp_pc}) begin
                    n_err++;
                    $display("FAIL q_hold: qv=%b op=%h ctrl=%0d tgt=%0d pc=%h, want stable offer pc=%h",
                             q_valid, q_op, q_ctrl, q_tgt, pc, exp_pc);
                end
            end
            q_ready = 1'b1; q_done = early_done;
            tick();
            q_ready = 1'b0; q_done = 1'b0;
            if (drop_run) run = 1'b0;
            n_vec++;
            if ({q_valid, busy, pc, retired} !== {2'b01, exp_pc, exp_ret}) begin
                n_err++;
                $display("FAIL q_accept: qv=%b busy=%b pc=%h ret=%0d, want 0 1 pc=%h ret=%0d",
                         q_valid, busy, pc, retired, exp_pc, exp_ret);
            end
            if (d_dly >= int'(QT)) begin
                repeat (QT - 1) tick();
                n_vec++;
                if ({busy, err} !== 2'b10) begin
                    n_err++;
                    $display("FAIL tmo_edge: busy=%b err=%b, want 1 0", busy, err);
                end
                tick();
                n_vec++;
                if ({busy, err, pc, retired} !== {2'b01, exp_pc, exp_ret}) begin
                    n_err++;
                    $display("FAIL timeout: busy=%b err=%b pc=%h ret=%0d, want 0 1 pc=%h ret=%0d",
                             busy, err, pc, retired, exp_pc, exp_ret);
                end
                halted = 1'b1;
                return;
            end
            repeat (d_dly) tick();
            q_done = 1'b1;
            tick();
            q_done = 1'b0;
            exp_pc  = exp_pc + 32'd4;
            exp_ret = exp_ret + 16'd1;
        end else begin
            tick();
            n_vec++;
            if ({c_valid, q_valid, c_instr} !== {2'b10, w}) begin
                n_err++;
                $display("FAIL c_offer: cv=%b qv=%b c_instr=%h, want 1 0 %h", c_valid, q_valid, c_instr, w);
            end
            for (int i = 0; i < c_hold; i++) begin
                tick();
                n_vec++;
                if ({c_valid, c_instr, pc} !== {1'b1, w, exp_pc}) begin
                    n_err++;
                    $display("FAIL c_hold: cv=%b c_instr=%h pc=%h, want 1 %h pc=%h", c_valid, c_instr, pc, w, exp_pc);
                end
            end
            c_ready = 1'b1;
            tick();
            c_ready = 1'b0;
            exp_pc  = exp_pc + 32'd4;
            exp_ret = exp_ret + 16'd1;
        end
        n_vec++;
        if ({busy, c_valid, q_valid, err, pc, retired} !== {4'b1000, exp_pc, exp_ret}) begin
            n_err++;
            $display("FAIL retire w=%h: busy,cv,qv,err=%b%b%b%b pc=%h ret=%0d, want 1000 pc=%h ret=%0d",
                     w, busy, c_valid, q_valid, err, pc, retired, exp_pc, exp_ret);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({pc, c_valid, c_instr, q_valid, q_op, q_ctrl, q_tgt, busy, err, retired} !== '0) begin
            n_err++;
            $display("FAIL reset_vals: pc=%h cv=%b ci=%h qv=%b op=%h busy=%b err=%b ret=%0d, want all 0",
                     pc, c_valid, c_instr, q_valid, q_op, busy, err, retired);
        end
        do_reset();
        tick();
        n_vec++;
        if ({busy, pc} !== {1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL idle_no_run: busy=%b pc=%h, want 0 0", busy, pc);
        end
    endtask

    task automatic test_program();
        load_demo();
        do_reset();
        start_run();
        for (int i = 0; i < 10; i++) exec_one(0, 0, 1, 1'b0, 1'b0);
        n_vec++;
        if ({pc, retired, err} !== {32'h4, 16'd10, 1'b0}) begin
            n_err++;
            $display("FAIL demo_loop: pc=%h ret=%0d err=%b, want 4 10 0", pc, retired, err);
        end
    endtask

    task automatic test_stalls();
        load_demo();
        do_reset();
        start_run();
        exec_one(3, 0, 1, 1'b0, 1'b0);
        exec_one(0, 5, 1, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        bad[0] = 32'h4802_0002;
        bad[1] = 32'h4803_0001;
        bad[2] = 32'h4821_0004;
        for (int i = 0; i < 3; i++) begin
            fill_nop();
            rom[0] = bad[i];
            do_reset();
            start_run();
            exec_one(0, 0, 0, 1'b0, 1'b0);
            repeat (3) tick();
            n_vec++;
            if ({busy, err, q_valid, pc} !== {3'b010, 32'h0}) begin
                n_err++;
                $display("FAIL illegal_stuck w=%h: busy=%b err=%b qv=%b pc=%h, want 0 1 0 0",
                         bad[i], busy, err, q_valid, pc);
            end
        end
    endtask

    task automatic test_timeout();
        fill_nop();
        rom[0] = 32'h4802_0001;
        do_reset();
        start_run();
        exec_one(0, 0, int'(QT), 1'b0, 1'b0);
        do_reset();
        start_run();
        exec_one(0, 0, int'(QT) - 1, 1'b0, 1'b0);
    endtask

    task automatic test_run_stop();
        load_demo();
        do_reset();
        start_run();
        exec_one(0, 0, 1, 1'b0, 1'b0);
        exec_one(0, 1, 2, 1'b0, 1'b1);
        tick();
        n_vec++;
        if ({busy, pc, retired} !== {1'b0, 32'h8, 16'd2}) begin
            n_err++;
            $display("FAIL stop_idle: busy=%b pc=%h ret=%0d, want 0 8 2", busy, pc, retired);
        end
        repeat (3) tick();
        start_run();
        exec_one(0, 0, 0, 1'b0, 1'b0);
        exec_one(0, 0, 0, 1'b0, 1'b0);
        n_vec++;
        if (pc !== 32'h4) begin
            n_err++;
            $display("FAIL resume_jump: pc=%h, want 4", pc);
        end
    endtask

    task automatic test_async_reset();
        load_demo();
        do_reset();
        start_run();
        tick();
        n_vec++;
        if (c_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_cv: cv=%b, want 1", c_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({c_valid, busy, pc} !== {2'b00, 32'h0}) begin
            n_err++;
            $display("FAIL async_reset: cv=%b busy=%b pc=%h, want 0 0 0", c_valid, busy, pc);
        end
        do_reset();
    endtask

    task automatic test_retired_wrap();
        fill_nop();
        rom[0] = 32'h0800_0000;
        do_reset();
        start_run();
        repeat (65535) tick();
        n_vec++;
        if ({retired, pc} !== {16'hFFFF, 32'h0}) begin
            n_err++;
            $display("FAIL ret_max: ret=%h pc=%h, want ffff 0", retired, pc);
        end
        tick();
        n_vec++;
        if ({retired, busy} !== {16'h0, 1'b1}) begin
            n_err++;
            $display("FAIL ret_wrap: ret=%h busy=%b, want 0 1", retired, busy);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        int          c;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: begin
                        w = $urandom;
                        while (w[31:26] == 6'b000010 || w[31:26] == 6'b010010) w = $urandom;
                    end
                    4, 5: w = {6'b010010, 5'($urandom_range(0, 31)), 5'($urandom_range(1, 2)), 10'($urandom), 6'h01};
                    6: begin
                        c = int'($urandom_range(1, 2));
                        w = {6'b010010, 5'(c), 5'(3 - c), 10'($urandom), 6'h04};
                    end
                    7, 8: w = {6'b000010, 26'($urandom_range(0, 63))};
                    default: w = {6'b010010, 20'($urandom), 6'($urandom_range(0, 7))};
                endcase
                rom[i] = w;
            end
            do_reset();
            start_run();
            for (int k = 0; k < 40 && !halted; k++)
                exec_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        fill_nop();
        exp_pc = 32'h0; exp_ret = 16'h0; halted = 1'b0;
        test_reset();
        test_program();
        test_stalls();
        test_illegal();
        test_timeout();
        test_run_stop();
        test_async_reset();
        test_random();
        test_retired_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
